wb_interconnect_n: RTL
======================

# wb_interconnect_n

Parametrised single-master, N-slave Wishbone interconnect for the user-project Wishbone port. Decodes the slave index from a master address field, registers the request toward exactly one slave, holds it until that slave acks, and returns a registered response to the master. Unmapped indices and, optionally, stalled slaves terminate with an error response so the management core cannot hang the bus.

## Interface
- NUM_SLAVES, 4: attached slaves, 1..16; slave k owns flattened lane k.
- SEL_LSB, 12: lowest master address bit of the slave-index field.
- SEL_W, 2: width of the slave-index field; 2**SEL_W >= NUM_SLAVES.
- SLV_ADR_W, 9: slave word-address width; slave address = m0_wb_adr_i[SLV_ADR_W+1:2].
- TIMEOUT_CYC, 255: cycles in WAIT before a timeout error, 1..65535.
- clk_i input 1: single clock, rising edge.
- rst input 1: reset; asynchronous, active-high.
- m0_wb_dat_i, m0_wb_adr_i input 32: master write data and byte address.
- m0_wb_sel_i input 4, m0_wb_we_i / m0_wb_cyc_i / m0_wb_stb_i input 1: master controls.
- m0_wb_dat_o output 32: read data, valid only with ack.
- m0_wb_ack_o, m0_wb_err_o output 1: one-cycle termination pulses; err is never asserted without ack.
- s_wb_dat_i input NUM_SLAVES*32, s_wb_ack_i input NUM_SLAVES: slave responses.
- s_wb_dat_o output NUM_SLAVES*32, s_wb_adr_o output NUM_SLAVES*SLV_ADR_W, s_wb_sel_o output NUM_SLAVES*4: slave request fields.
- s_wb_we_o, s_wb_cyc_o, s_wb_stb_o output NUM_SLAVES: slave controls.

## Operation
- FSM: IDLE, WAIT, RESP.
- IDLE:
  - When m0 cyc&stb are high, capture the index idx = m0_wb_adr_i[SEL_LSB +: SEL_W] and the request fields.
  - If idx < NUM_SLAVES, go to WAIT. Otherwise go to RESP with err=1 and data 32'hDEAD_0000.
- WAIT:
  - Only lane idx drives the registered dat/adr/sel/we and cyc=stb=1. Every other lane is all-zero.
  - When s_wb_ack_i[idx]=1, capture s_wb_dat_i lane idx, drop the slave cyc/stb on the next edge, and go to RESP with err=0.
  - If m0_wb_cyc_i drops, abort: clear slave controls on the next edge, return to IDLE, and issue no ack.
- RESP:
  - Drives m0_wb_ack_o=1 for exactly one cycle, with the captured data and err. Then go to IDLE.
  - The master must drop stb on ack. A request still present in the cycle after RESP is treated as a new transaction.
- Acks from non-selected slaves, and any ack while in IDLE or RESP, are ignored.
- All slave outputs and m0 ack/dat/err come from flops; there is no combinational path from master to slave.

## Timing
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-transaction clears the state asynchronously; no ack is issued for the aborted transfer.
- Request seen at edge E0 → slave cyc/stb high after E0.
- Slave acks in cycle n after E0 → master ack in cycle n+1. Minimum latency with a zero-wait slave is master ack two cycles after the request edge.
- Unmapped index: master ack+err one cycle after the request edge.
- Back-to-back: the next request is accepted at the edge after the RESP cycle. Minimum 3 cycles per transfer.
- Counter rules: the timeout counter clears on WAIT entry and increments each WAIT cycle. Width is 16 bits; it saturates and never wraps.

## Configuration
- WB_IC_TIMEOUT_EN defined:
  - Timeout fires when the counter reaches TIMEOUT_CYC with no ack: go to RESP with err=1 and data 32'hDEAD_0001, and drop the slave cyc/stb.
  - Slave ack and timeout in the same cycle: the slave ack wins with err=0.
- Undefined: the counter logic is absent and WAIT lasts until ack or master abort. Unmapped-index errors remain.

## Test plan
- Write idx 0: adr 0x0000_0010, dat 0xA5A5_1234, sel 0xF, slave acks on first stb cycle → lane 0 sees adr 9'h004, we=1, dat 0xA5A5_1234. Master ack two cycles after request, err=0. Lane 1 all zeros.
- Read idx 1 with 3 wait states: adr 0x0000_1008, slave returns 0x0000_00C3 → master ack with dat 0x0000_00C3 at cycle 5.
- Unmapped: NUM_SLAVES=3, adr 0x0000_3000 → no slave cyc. Ack+err one cycle later, dat 0xDEAD_0000.
- Timeout (WB_IC_TIMEOUT_EN, TIMEOUT_CYC=8): slave never acks → ack+err, dat 0xDEAD_0001. Slave cyc drops on the same edge.
- Ack from slave 2 while slave 0 is selected → ignored. Lane 0 then acks → normal completion, err=0.
- rst asserted asynchronously in WAIT → all outputs 0 immediately. After release, a new write to idx 0 completes normally.

Source files
------------

// File: rtl/wb_interconnect_n.sv
// wb_interconnect_n
//   Single-master, N-slave Wishbone interconnect. The slave index is taken
//   from m0_wb_adr_i[SEL_LSB +: SEL_W]. The request is registered toward
//   exactly one slave lane and held until that slave acks. The response is
//   then returned to the master as a registered one-cycle ack. An unmapped
//   index is terminated with ack+err and data 32'hDEAD_0000.
//
//   Optional feature macro: WB_IC_TIMEOUT_EN. When it is defined, a stalled
//   slave is cut off after TIMEOUT_CYC cycles in WAIT. The master then gets
//   ack+err with data 32'hDEAD_0001.
//
//   Ports
//     clk_i, rst                     clock, async active-high reset
//     m0_wb_*_i / m0_wb_*_o          master side (dat/adr/sel/we/cyc/stb in,
//                                    dat/ack/err out)
//     s_wb_dat_i, s_wb_ack_i         flattened slave responses, lane k = slave k
//     s_wb_dat/adr/sel/we/cyc/stb_o  flattened registered slave requests
module wb_interconnect_n #(
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = 12,
  parameter int SEL_W       = 2,
  parameter int SLV_ADR_W   = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk_i,
  input  logic                            rst,
  input  logic [31:0]                     m0_wb_dat_i,
  input  logic [31:0]                     m0_wb_adr_i,
  input  logic [3:0]                      m0_wb_sel_i,
  input  logic                            m0_wb_we_i,
  input  logic                            m0_wb_cyc_i,
  input  logic                            m0_wb_stb_i,
  output logic [31:0]                     m0_wb_dat_o,
  output logic                            m0_wb_ack_o,
  output logic                            m0_wb_err_o,
  input  logic [NUM_SLAVES*32-1:0]        s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_wb_ack_i,
  output logic [NUM_SLAVES*32-1:0]        s_wb_dat_o,
  output logic [NUM_SLAVES*SLV_ADR_W-1:0] s_wb_adr_o,
  output logic [NUM_SLAVES*4-1:0]         s_wb_sel_o,
  output logic [NUM_SLAVES-1:0]           s_wb_we_o,
  output logic [NUM_SLAVES-1:0]           s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_wb_stb_o
);

  localparam logic [31:0] DAT_UNMAPPED = 32'hDEAD_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                          state_q;
  logic [SEL_W-1:0]                idx_q;
  logic [NUM_SLAVES*32-1:0]        s_dat_q;
  logic [NUM_SLAVES*SLV_ADR_W-1:0] s_adr_q;
  logic [NUM_SLAVES*4-1:0]         s_sel_q;
  logic [NUM_SLAVES-1:0]           s_we_q;
  logic [NUM_SLAVES-1:0]           s_cyc_q;
  logic [NUM_SLAVES-1:0]           s_stb_q;
  logic [31:0]                     m0_dat_q;
  logic                            m0_ack_q;
  logic                            m0_err_q;

  // Decode of the incoming request and of the selected slave's response.
  logic [SEL_W-1:0] idx_d;
  logic             mapped_d;
  logic             ack_hit_d;
  logic [31:0]      rdat_d;

  assign idx_d    = m0_wb_adr_i[SEL_LSB +: SEL_W];
  assign mapped_d = (32'(idx_d) < 32'(NUM_SLAVES));

  // Only the selected lane's ack/data matter; all other acks are ignored.
  always_comb begin
    ack_hit_d = 1'b0;
    rdat_d    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) begin
        ack_hit_d = s_wb_ack_i[k];
        rdat_d    = s_wb_dat_i[k*32 +: 32];
      end
    end
  end

  // Address bits outside the slave word address are intentionally unused.
  logic unused_adr;
  assign unused_adr = ^{m0_wb_adr_i[1:0], m0_wb_adr_i[31:SLV_ADR_W+2]};

`ifdef WB_IC_TIMEOUT_EN
  localparam logic [31:0] DAT_TIMEOUT = 32'hDEAD_0001;

  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;
  logic        tmo_fire_d;

  // Saturating increment; the counter never wraps.
  assign tmo_cnt_d  = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
  assign tmo_fire_d = (tmo_cnt_d >= 16'(TIMEOUT_CYC));

  // WAIT is only entered from IDLE, so clearing in IDLE gives 0 on WAIT entry.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYC);
`endif

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      s_dat_q  <= '0;
      s_adr_q  <= '0;
      s_sel_q  <= '0;
      s_we_q   <= '0;
      s_cyc_q  <= '0;
      s_stb_q  <= '0;
      m0_dat_q <= '0;
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
    end else begin
      // Master response is a single-cycle pulse unless set below.
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m0_dat_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (m0_wb_cyc_i && m0_wb_stb_i) begin
            idx_q <= idx_d;
            if (mapped_d) begin
              // All lanes are zero in IDLE, so only the selected lane is loaded.
              for (int k = 0; k < NUM_SLAVES; k++) begin
                if (idx_d == SEL_W'(k)) begin
                  s_dat_q[k*32 +: 32]               <= m0_wb_dat_i;
                  s_adr_q[k*SLV_ADR_W +: SLV_ADR_W] <= m0_wb_adr_i[SLV_ADR_W+1:2];
                  s_sel_q[k*4 +: 4]                 <= m0_wb_sel_i;
                  s_we_q[k]                         <= m0_wb_we_i;
                  s_cyc_q[k]                        <= 1'b1;
                  s_stb_q[k]                        <= 1'b1;
                end
              end
              state_q <= ST_WAIT;
            end else begin
              m0_ack_q <= 1'b1;
              m0_err_q <= 1'b1;
              m0_dat_q <= DAT_UNMAPPED;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // An abort by the master takes priority; no ack is returned for it.
          if (!m0_wb_cyc_i) begin
            s_dat_q <= '0;
            s_adr_q <= '0;
            s_sel_q <= '0;
            s_we_q  <= '0;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= ST_IDLE;
          end else if (ack_hit_d) begin
            s_dat_q  <= '0;
            s_adr_q  <= '0;
            s_sel_q  <= '0;
            s_we_q   <= '0;
            s_cyc_q  <= '0;
            s_stb_q  <= '0;
            m0_ack_q <= 1'b1;
            m0_dat_q <= rdat_d;
            state_q  <= ST_RESP;
          end
`ifdef WB_IC_TIMEOUT_EN
          else if (tmo_fire_d) begin
            s_dat_q  <= '0;
            s_adr_q  <= '0;
            s_sel_q  <= '0;
            s_we_q   <= '0;
            s_cyc_q  <= '0;
            s_stb_q  <= '0;
            m0_ack_q <= 1'b1;
            m0_err_q <= 1'b1;
            m0_dat_q <= DAT_TIMEOUT;
            state_q  <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_wb_dat_o = m0_dat_q;
  assign m0_wb_ack_o = m0_ack_q;
  assign m0_wb_err_o = m0_err_q;
  assign s_wb_dat_o  = s_dat_q;
  assign s_wb_adr_o  = s_adr_q;
  assign s_wb_sel_o  = s_sel_q;
  assign s_wb_we_o   = s_we_q;
  assign s_wb_cyc_o  = s_cyc_q;
  assign s_wb_stb_o  = s_stb_q;

endmodule
